// File: rtl/seg7_pkg.sv
// seg7_pkg
// Shared definitions for the 7-segment-to-byte recovery path.
//   - SEG_x : active-high segment codes for hex digits 0..F, A at bit 6, G at bit 0.
//             The display bus is active-low, so a digit appears on the pins as ~SEG_x.
//   - state_t : FSM encoding used by seg7_to_byte.
package seg7_pkg;

   localparam logic [6:0] SEG_0 = 7'h7E;
   localparam logic [6:0] SEG_1 = 7'h30;
   localparam logic [6:0] SEG_2 = 7'h6D;
   localparam logic [6:0] SEG_3 = 7'h79;
   localparam logic [6:0] SEG_4 = 7'h33;
   localparam logic [6:0] SEG_5 = 7'h5B;
   localparam logic [6:0] SEG_6 = 7'h5F;
   localparam logic [6:0] SEG_7 = 7'h70;
   localparam logic [6:0] SEG_8 = 7'h7F;
   localparam logic [6:0] SEG_9 = 7'h7B;
   localparam logic [6:0] SEG_A = 7'h77;
   localparam logic [6:0] SEG_B = 7'h1F;
   localparam logic [6:0] SEG_C = 7'h4E;
   localparam logic [6:0] SEG_D = 7'h3D;
   localparam logic [6:0] SEG_E = 7'h4F;
   localparam logic [6:0] SEG_F = 7'h47;

   typedef enum logic [1:0] {
      WAIT_STABLE = 2'd0,
      DECODE      = 2'd1,
      WAIT_TX     = 2'd2,
      SEND        = 2'd3
   } state_t;

endpackage

// File: rtl/seg7_digit_decode.sv
// seg7_digit_decode
// Combinational decode of one active-low 7-segment digit to a hex nibble.
//   pattern : in,  7 b, pin values (0 = lit), bit6 = A .. bit0 = G
//   nibble  : out, 4 b, decoded hex value (0 when illegal)
//   legal   : out, 1 b, high when the pattern is one of the 16 hex glyphs
module seg7_digit_decode
   import seg7_pkg::*;
(
   input  logic [6:0] pattern,
   output logic [3:0] nibble,
   output logic       legal
);

   always_comb begin
      nibble = 4'h0;
      legal  = 1'b1;
      case (~pattern)
         SEG_0:   nibble = 4'h0;
         SEG_1:   nibble = 4'h1;
         SEG_2:   nibble = 4'h2;
         SEG_3:   nibble = 4'h3;
         SEG_4:   nibble = 4'h4;
         SEG_5:   nibble = 4'h5;
         SEG_6:   nibble = 4'h6;
         SEG_7:   nibble = 4'h7;
         SEG_8:   nibble = 4'h8;
         SEG_9:   nibble = 4'h9;
         SEG_A:   nibble = 4'hA;
         SEG_B:   nibble = 4'hB;
         SEG_C:   nibble = 4'hC;
         SEG_D:   nibble = 4'hD;
         SEG_E:   nibble = 4'hE;
         SEG_F:   nibble = 4'hF;
         default: legal  = 1'b0;
      endcase
   end

endmodule

// File: rtl/seg7_to_byte.sv
// seg7_to_byte
// Watches two active-low 7-segment digits on an asynchronous display bus and
// forwards each newly settled legal digit pair to the UART TX as one byte.
//   i_Clk        : in,  1 b, system clock
//   i_Rst        : in,  1 b, asynchronous active-high reset
//   i_Segment1   : in,  7 b, upper-nibble digit, active-low, bit6 = A
//   i_Segment2   : in,  7 b, lower-nibble digit, active-low, bit6 = A
//   i_TX_Active  : in,  1 b, UART busy; holds off new sends
//   o_TX_DV      : out, 1 b, one-clock strobe qualifying o_TX_Byte
//   o_TX_Byte    : out, 8 b, {nibble(Segment1), nibble(Segment2)}
//   o_Err        : out, 1 b, one-clock pulse for an accepted pair with an illegal digit
//
// state       | meaning
// WAIT_STABLE | waiting for a settled pattern that differs from the last accepted one
// DECODE      | pattern latched; branch on legality (illegal -> o_Err pulse)
// WAIT_TX     | legal byte held, waiting for the UART to go idle
// SEND        | o_TX_DV high for this clock with the held byte
module seg7_to_byte
   import seg7_pkg::*;
#(
   parameter int STABLE_CYCLES = 16
) (
   input  logic       i_Clk,
   input  logic       i_Rst,
   input  logic [6:0] i_Segment1,
   input  logic [6:0] i_Segment2,
   input  logic       i_TX_Active,
   output logic       o_TX_DV,
   output logic [7:0] o_TX_Byte,
   output logic       o_Err
);

   localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

   logic [13:0]      sync_meta;
   logic [13:0]      sync_pat;
   logic [13:0]      sync_prev;
   logic [CNT_W-1:0] held_cnt;
   logic [CNT_W-1:0] held_now;
   logic             stable;
   logic [13:0]      last_pattern;
   logic [7:0]       held_byte;
   logic             held_legal;
   logic [3:0]       nib_hi;
   logic [3:0]       nib_lo;
   logic             legal_hi;
   logic             legal_lo;
   logic             take;
   state_t           state;
   state_t           state_next;

   seg7_digit_decode u_dec_hi (
      .pattern (sync_pat[13:7]),
      .nibble  (nib_hi),
      .legal   (legal_hi)
   );

   seg7_digit_decode u_dec_lo (
      .pattern (sync_pat[6:0]),
      .nibble  (nib_lo),
      .legal   (legal_lo)
   );

   // held_now counts the clocks, including the current one, that sync_pat has
   // held its value; the register keeps last cycle's figure. Counting the
   // current cycle lets the FSM act in the same clock the pattern reaches
   // STABLE_CYCLES rather than one clock later.
   always_comb begin
      held_now = CNT_W'(1);
      if (sync_pat == sync_prev) begin
         held_now = (held_cnt == CNT_MAX) ? CNT_MAX : held_cnt + CNT_W'(1);
      end
   end

   assign stable = (held_now == CNT_MAX);
   assign take   = (state == WAIT_STABLE) && (state_next == DECODE);

   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         sync_meta <= '1;
         sync_pat  <= '1;
         sync_prev <= '1;
         held_cnt  <= '0;
      end else begin
         sync_meta <= {i_Segment1, i_Segment2};
         sync_pat  <= sync_meta;
         sync_prev <= sync_pat;
         held_cnt  <= held_now;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         WAIT_STABLE: if (stable && (sync_pat != last_pattern)) state_next = DECODE;
         DECODE:      state_next = held_legal ? WAIT_TX : WAIT_STABLE;
         WAIT_TX:     if (!i_TX_Active) state_next = SEND;
         SEND:        state_next = WAIT_STABLE;
         default:     state_next = WAIT_STABLE;
      endcase
   end

   // The pattern is captured on the way into DECODE so later input activity
   // cannot disturb the byte being sent; the counter keeps running regardless.
   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         state        <= WAIT_STABLE;
         last_pattern <= '1;
         held_byte    <= 8'h00;
         held_legal   <= 1'b0;
         o_TX_DV      <= 1'b0;
         o_TX_Byte    <= 8'h00;
         o_Err        <= 1'b0;
      end else begin
         state   <= state_next;
         o_Err   <= (state == DECODE) && !held_legal;
         o_TX_DV <= (state_next == SEND);
         if (take) begin
            last_pattern <= sync_pat;
            held_byte    <= {nib_hi, nib_lo};
            held_legal   <= legal_hi && legal_lo;
         end
         if (state_next == SEND) begin
            o_TX_Byte <= held_byte;
         end
      end
   end

endmodule

// File: doc/seg7_to_byte.md
# seg7_to_byte

Recovers a byte from two active-low 7-segment digit patterns, the inverse of our binary-to-7-segment hex encoder, and forwards it to the UART transmitter. It sits between a monitored display bus (asynchronous source) and the UART TX byte interface. It synchronises and debounces the segment lines and decodes each digit to a hex nibble. Each new legal pattern pair is sent exactly once; illegal patterns raise an error pulse.

## Interface
- STABLE_CYCLES, default 16: consecutive clocks a synchronised pattern must stay unchanged before it is accepted; legal range ≥1.
- i_Clk  input  1  system clock.
- i_Rst  input  1  reset; asynchronous, active-high.
- i_Segment1  input  7  upper-nibble digit; bit6=A … bit0=G; active-low (0 = lit).
- i_Segment2  input  7  lower-nibble digit; same bit mapping.
- i_TX_Active  input  1  UART TX busy; high blocks new sends.
- o_TX_DV  output  1  one-clock strobe; o_TX_Byte is valid while it is high.
- o_TX_Byte  output  8  {nibble(Segment1), nibble(Segment2)}.
- o_Err  output  1  one-clock pulse when an accepted pattern pair contains an illegal digit.

## Operation
- Segment map before inversion (A..G): 0=7E 1=30 2=6D 3=79 4=33 5=5B 6=5F 7=70 8=7F 9=7B A=77 b=1F C=4E d=3D E=4F F=47.
  - Input is active-low, so pin value = ~code.
  - Any other 7-bit value is illegal, including blank (all pins high).
- Two-flop synchroniser on all 14 input bits. Everything downstream uses the synchronised value.
- Stability counter:
  - Clears whenever the synchronised pattern differs from its previous-cycle value.
  - Otherwise increments, saturating at STABLE_CYCLES.
  - The pattern is "stable" while the count equals STABLE_CYCLES.
- r_Last_Pattern (14 b) holds the last accepted pattern. Reset value is all ones (both digits blank).
- FSM:
  - WAIT_STABLE: go to DECODE when stable and the pattern ≠ r_Last_Pattern; else stay.
  - DECODE: latch the pattern into r_Last_Pattern and the decoded byte into a holding register.
    - If both digits are legal, go to WAIT_TX.
    - Otherwise pulse o_Err and return to WAIT_STABLE.
  - WAIT_TX: go to SEND when i_TX_Active is low.
  - SEND: o_TX_DV=1 and o_TX_Byte=held byte for this one clock; then go to WAIT_STABLE.
- Reset values: o_TX_DV=0, o_TX_Byte=8'h00, o_Err=0, FSM=WAIT_STABLE, counter=0, synchronisers=all ones.

## Timing
- Count edge 1 as the first clock edge that samples a new input value, with i_TX_Active low. Then:
  - o_TX_DV is high in the cycle after edge STABLE_CYCLES+4.
  - o_Err is high in the cycle after edge STABLE_CYCLES+3.
- o_TX_Byte changes only on entry to SEND. It holds its value otherwise.
- The same pattern is never re-sent or re-flagged until a different pattern has been accepted, including an illegal one.
- Input changes during DECODE/WAIT_TX/SEND do not alter the held byte. The new pattern is evaluated after returning to WAIT_STABLE; the counter keeps running meanwhile.
- Glitches shorter than STABLE_CYCLES clocks on the synchronised value are ignored.
- i_TX_Active high at entry to WAIT_TX holds the FSM there indefinitely. o_TX_DV must not assert while i_TX_Active is high.
- Asserting i_Rst mid-operation returns all state to reset values immediately. A pending byte is dropped and no strobe is emitted.

## Structure
- Package seg7_pkg:
  - the 16 segment-code constants (active-high, A at bit 6);
  - the FSM state encoding.
- Sub-module seg7_digit_decode:
  - combinational: 7-bit active-low pattern → 4-bit nibble + legal flag;
  - instantiated twice.
- Top holds the synchroniser, stability counter, FSM and output registers.

## Test plan
1. Reset, then drive ~7E/~30 (digits 0,1) with STABLE_CYCLES=4 → one o_TX_DV pulse, o_TX_Byte=8'h01, first high after edge 8. No o_Err.
2. Sweep all 256 legal pattern pairs, each held 10 clocks → exactly 256 strobes, bytes 00..FF in order.
3. Segment1=~4F, Segment2 toggled between ~47 and ~4E every 2 clocks for 20 clocks, then held at ~47 → a single strobe with 8'hEF, none during toggling.
4. Segment1=~7F (legal 8), Segment2=7'b1010101 (illegal) → one o_Err pulse, no strobe. The same pattern held 100 clocks produces no further pulses.
5. i_TX_Active high, apply ~79/~5B (3,5) → FSM waits and no strobe. Change inputs to ~33/~33 meanwhile, then drop i_TX_Active → strobe 8'h35 first, then 8'h44 after stabilisation.
6. Assert i_Rst while in WAIT_TX → no strobe, outputs zero. After release, blank input produces nothing, and re-applying the same legal pattern is sent once.
